// File: rtl/axi_dma_rd_desc_sched.sv
// Round-robin descriptor scheduler: N requester ports share one DMA read engine,
// with a per-port in-flight limit and status return routed by the tag's port field.
module axi_dma_rd_desc_sched #(
  parameter int PORTS           = 4,
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 20,
  parameter int S_TAG_WIDTH     = 8,
  parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
  parameter int AXIS_ID_WIDTH   = 8,
  parameter int AXIS_USER_WIDTH = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PORTS*AXI_ADDR_WIDTH-1:0]    s_axis_read_desc_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]         s_axis_read_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0]       s_axis_read_desc_tag,
  input  logic [PORTS*AXIS_ID_WIDTH-1:0]     s_axis_read_desc_id,
  input  logic [PORTS*AXIS_USER_WIDTH-1:0]   s_axis_read_desc_user,
  input  logic [PORTS-1:0]                   s_axis_read_desc_valid,
  output logic [PORTS-1:0]                   s_axis_read_desc_ready,
  output logic [PORTS*S_TAG_WIDTH-1:0]       s_axis_read_desc_status_tag,
  output logic [PORTS-1:0]                   s_axis_read_desc_status_valid,
  output logic [AXI_ADDR_WIDTH-1:0]          m_axis_read_desc_addr,
  output logic [LEN_WIDTH-1:0]               m_axis_read_desc_len,
  output logic [M_TAG_WIDTH-1:0]             m_axis_read_desc_tag,
  output logic [AXIS_ID_WIDTH-1:0]           m_axis_read_desc_id,
  output logic [AXIS_USER_WIDTH-1:0]         m_axis_read_desc_user,
  output logic                               m_axis_read_desc_valid,
  input  logic                               m_axis_read_desc_ready,
  input  logic [M_TAG_WIDTH-1:0]             m_axis_read_desc_status_tag,
  input  logic                               m_axis_read_desc_status_valid,
  input  logic                               enable,
  output logic                               busy
);

  localparam int PW  = $clog2(PORTS);
  localparam int SPW = M_TAG_WIDTH - S_TAG_WIDTH;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never waits for ready, and a raised valid holds its payload until it transfers.

  logic [CW-1:0]    cnt     [PORTS];
  logic [CW-1:0]    cnt_nxt [PORTS];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    cand;
  logic [PORTS-1:0] elig;
  logic [PORTS-1:0] st_dec;
  logic [SPW-1:0]   st_port;
  logic             gnt_found;
  logic             load;
  logic             grant;
  logic             m_valid_nxt;
  logic             any_nz;

  assign st_port     = m_axis_read_desc_status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH];
  assign load        = !m_axis_read_desc_valid || m_axis_read_desc_ready;
  assign grant       = rst_n && load && gnt_found;
  assign m_valid_nxt = grant || (m_axis_read_desc_valid && !m_axis_read_desc_ready);

  // Ports at their in-flight limit are simply not eligible, so they never move ptr.
  always_comb begin : arb
    elig      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < PORTS; i++)
      elig[i] = s_axis_read_desc_valid[i] && enable && (cnt[i] < CW'(MAX_OUTSTANDING));
    for (int off = 0; off < PORTS; off++) begin
      cand = PW'((int'(ptr) + off) % PORTS);
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin : ready_dec
    s_axis_read_desc_ready = '0;
    if (grant) s_axis_read_desc_ready[gnt_idx] = 1'b1;
  end

  // Out-of-range port fields never match any i, so they are dropped here too.
  always_comb begin : status_match
    st_dec = '0;
    for (int i = 0; i < PORTS; i++)
      st_dec[i] = m_axis_read_desc_status_valid && (st_port == SPW'(i)) && (cnt[i] != '0);
  end

  always_comb begin : cnt_next
    any_nz = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (grant && (gnt_idx == PW'(i)) && !st_dec[i])
        cnt_nxt[i] = cnt[i] + CW'(1);
      else if (st_dec[i] && !(grant && (gnt_idx == PW'(i))))
        cnt_nxt[i] = cnt[i] - CW'(1);
      any_nz = any_nz || (cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_read_desc_valid        <= 1'b0;
      m_axis_read_desc_addr         <= '0;
      m_axis_read_desc_len          <= '0;
      m_axis_read_desc_tag          <= '0;
      m_axis_read_desc_id           <= '0;
      m_axis_read_desc_user         <= '0;
      s_axis_read_desc_status_valid <= '0;
      s_axis_read_desc_status_tag   <= '0;
      ptr                           <= '0;
      busy                          <= 1'b0;
      for (int i = 0; i < PORTS; i++) cnt[i] <= '0;
    end else begin
      m_axis_read_desc_valid        <= m_valid_nxt;
      busy                          <= m_valid_nxt || any_nz;
      s_axis_read_desc_status_valid <= st_dec;
      for (int i = 0; i < PORTS; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (st_dec[i])
          s_axis_read_desc_status_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH] <=
            m_axis_read_desc_status_tag[S_TAG_WIDTH-1:0];
      end
      if (grant) begin
        m_axis_read_desc_addr <= s_axis_read_desc_addr[int'(gnt_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        m_axis_read_desc_len  <= s_axis_read_desc_len[int'(gnt_idx)*LEN_WIDTH +: LEN_WIDTH];
        m_axis_read_desc_id   <= s_axis_read_desc_id[int'(gnt_idx)*AXIS_ID_WIDTH +: AXIS_ID_WIDTH];
        m_axis_read_desc_user <= s_axis_read_desc_user[int'(gnt_idx)*AXIS_USER_WIDTH +: AXIS_USER_WIDTH];
        m_axis_read_desc_tag  <= M_TAG_WIDTH'({gnt_idx,
                                   s_axis_read_desc_tag[int'(gnt_idx)*S_TAG_WIDTH +: S_TAG_WIDTH]});
        ptr <= (gnt_idx == PW'(PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_dma_rd_desc_sched.sv
// Bench for axi_dma_rd_desc_sched: scenario tasks drive ports, a negedge monitor
// pops expected descriptors and status pulses from queues and compares.
module tb_axi_dma_rd_desc_sched;
  localparam int P  = 4;
  localparam int AW = 16;
  localparam int LW = 20;
  localparam int SW = 8;
  localparam int MW = 10;
  localparam int IW = 8;
  localparam int UW = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [P*AW-1:0] s_addr;
  logic [P*LW-1:0] s_len;
  logic [P*SW-1:0] s_tag;
  logic [P*IW-1:0] s_id;
  logic [P*UW-1:0] s_user;
  logic [P-1:0]    s_valid;
  logic [P-1:0]    s_ready;
  logic [P*SW-1:0] s_st_tag;
  logic [P-1:0]    s_st_valid;
  logic [AW-1:0]   m_addr;
  logic [LW-1:0]   m_len;
  logic [MW-1:0]   m_tag;
  logic [IW-1:0]   m_id;
  logic [UW-1:0]   m_user;
  logic            m_valid;
  logic            m_ready;
  logic [MW-1:0]   m_st_tag;
  logic            m_st_valid;
  logic            enable;
  logic            busy;

  axi_dma_rd_desc_sched dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .s_axis_read_desc_addr         (s_addr),
    .s_axis_read_desc_len          (s_len),
    .s_axis_read_desc_tag          (s_tag),
    .s_axis_read_desc_id           (s_id),
    .s_axis_read_desc_user         (s_user),
    .s_axis_read_desc_valid        (s_valid),
    .s_axis_read_desc_ready        (s_ready),
    .s_axis_read_desc_status_tag   (s_st_tag),
    .s_axis_read_desc_status_valid (s_st_valid),
    .m_axis_read_desc_addr         (m_addr),
    .m_axis_read_desc_len          (m_len),
    .m_axis_read_desc_tag          (m_tag),
    .m_axis_read_desc_id           (m_id),
    .m_axis_read_desc_user         (m_user),
    .m_axis_read_desc_valid        (m_valid),
    .m_axis_read_desc_ready        (m_ready),
    .m_axis_read_desc_status_tag   (m_st_tag),
    .m_axis_read_desc_status_valid (m_st_valid),
    .enable                        (enable),
    .busy                          (busy)
  );

  int pass_cnt = 0;
  int total    = 0;
  logic [54:0] exp_q[$];
  logic [9:0]  exp_st_q[$];
  logic [9:0]  infl_q[$];
  logic [7:0]  tagv[P];

  function automatic logic [15:0] f_addr(int p, logic [7:0] t);
    return 16'(p * 4096) | {4'h0, t, 4'h0};
  endfunction
  function automatic logic [19:0] f_len(int p, logic [7:0] t);
    return {12'(p + 1), t};
  endfunction
  function automatic logic [7:0] f_id(int p);
    return 8'(160 + p);
  endfunction
  function automatic logic [54:0] dw(int p, logic [7:0] t);
    return {2'(p), t, f_addr(p, t), f_len(p, t), f_id(p), t[0]};
  endfunction

  task automatic set_desc(int p, logic [7:0] t);
    s_addr[p*AW +: AW] = f_addr(p, t);
    s_len[p*LW +: LW]  = f_len(p, t);
    s_tag[p*SW +: SW]  = t;
    s_id[p*IW +: IW]   = f_id(p);
    s_user[p*UW +: UW] = t[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every DMA-side transfer and every status pulse pops one entry.
  always @(negedge clk) begin : monitor
    logic [54:0] e;
    logic [9:0]  es;
    if (rst_n) begin
      if (m_valid && m_ready) begin
        total++;
        if (exp_q.size() == 0)
          $display("FAIL m_desc_unexpected got %h want none", {m_tag, m_addr, m_len, m_id, m_user});
        else begin
          e = exp_q.pop_front();
          if ({m_tag, m_addr, m_len, m_id, m_user} !== e)
            $display("FAIL m_desc got %h want %h", {m_tag, m_addr, m_len, m_id, m_user}, e);
          else pass_cnt++;
        end
      end
      for (int i = 0; i < P; i++) begin
        if (s_st_valid[i]) begin
          total++;
          if (exp_st_q.size() == 0)
            $display("FAIL status_unexpected port %0d got %h want none", i, s_st_tag[i*SW +: SW]);
          else begin
            es = exp_st_q.pop_front();
            if ({2'(i), s_st_tag[i*SW +: SW]} !== es)
              $display("FAIL status got %h want %h", {2'(i), s_st_tag[i*SW +: SW]}, es);
            else pass_cnt++;
          end
        end
      end
    end
  end

  task automatic drain_status();
    logic [9:0] it;
    while (infl_q.size() > 0) begin
      it = infl_q.pop_front();
      m_st_tag = it; m_st_valid = 1'b1;
      exp_st_q.push_back(it);
      step();
      m_st_valid = 1'b0;
      @(negedge clk);
      total++;
      if (s_st_valid !== 4'(1 << it[9:8]))
        $display("FAIL status_pulse got %b want %b", s_st_valid, 4'(1 << it[9:8]));
      else pass_cnt++;
    end
    step(); step();
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL busy_idle got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; m_ready = 1'b1; s_valid = '1;
    m_st_tag = '0; m_st_valid = 1'b0;
    for (int p = 0; p < P; p++) set_desc(p, 8'(p));
    @(negedge clk);
    total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else pass_cnt++;
    total++;
    if ({m_tag, m_addr, m_len, m_id, m_user} !== 55'd0)
      $display("FAIL reset_fields got %h want 0", {m_tag, m_addr, m_len, m_id, m_user});
    else pass_cnt++;
    total++; if (s_st_valid !== 4'b0) $display("FAIL reset_st_valid got %b want 0", s_st_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (s_ready !== 4'b0) $display("FAIL reset_ready got %b want 0", s_ready); else pass_cnt++;
    s_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    step();
    for (int p = 0; p < P; p++) begin
      tagv[p] = 8'($urandom_range(0, 200));
      set_desc(p, tagv[p]);
    end
    enable = 1'b1; m_ready = 1'b1; s_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % P;
      @(negedge clk);
      total++;
      if (s_ready !== 4'(1 << e)) $display("FAIL rr_grant%0d got %b want %b", k, s_ready, 4'(1 << e));
      else pass_cnt++;
      exp_q.push_back(dw(e, tagv[e]));
      infl_q.push_back({2'(e), tagv[e]});
      step();
      tagv[e]++;
      set_desc(e, tagv[e]);
    end
    s_valid = '0;
    step();
    drain_status();
  endtask

  task automatic test_hold();
    logic [15:0] held;
    step();
    m_ready = 1'b0;
    tagv[2] = 8'($urandom_range(0, 255));
    set_desc(2, tagv[2]);
    s_valid = 4'b0100;
    @(negedge clk);
    total++; if (s_ready !== 4'b0100) $display("FAIL hold_first_grant got %b want 0100", s_ready); else pass_cnt++;
    exp_q.push_back(dw(2, tagv[2]));
    infl_q.push_back({2'd2, tagv[2]});
    held = f_addr(2, tagv[2]);
    step();
    tagv[2]++;
    set_desc(2, tagv[2]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (s_ready !== 4'b0) $display("FAIL hold_no_ready got %b want 0", s_ready); else pass_cnt++;
      total++;
      if (m_valid !== 1'b1 || m_addr !== held)
        $display("FAIL hold_stable got %b/%h want 1/%h", m_valid, m_addr, held);
      else pass_cnt++;
    end
    step();
    m_ready = 1'b1;
    @(negedge clk);
    total++; if (s_ready !== 4'b0100) $display("FAIL hold_release_grant got %b want 0100", s_ready); else pass_cnt++;
    exp_q.push_back(dw(2, tagv[2]));
    infl_q.push_back({2'd2, tagv[2]});
    step();
    s_valid = '0;
    step();
    drain_status();
  endtask

  task automatic test_max_outstanding();
    logic [9:0] tmp;
    step();
    m_ready = 1'b1;
    tagv[1] = 8'h05;
    set_desc(1, tagv[1]);
    s_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (s_ready !== 4'b0010) $display("FAIL max_grant%0d got %b want 0010", k, s_ready); else pass_cnt++;
      exp_q.push_back(dw(1, tagv[1]));
      infl_q.push_back({2'd1, tagv[1]});
      step();
      tagv[1]++;
      set_desc(1, tagv[1]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (s_ready !== 4'b0) $display("FAIL max_blocked got %b want 0", s_ready); else pass_cnt++;
    end
    step();
    m_st_tag = {2'd1, 8'h05}; m_st_valid = 1'b1;
    exp_st_q.push_back({2'd1, 8'h05});
    tmp = infl_q.pop_front();
    step();
    m_st_valid = 1'b0;
    @(negedge clk);
    total++;
    if (s_st_valid !== 4'b0010 || s_st_tag[15:8] !== 8'h05)
      $display("FAIL max_status_pulse got %b/%h want 0010/05 (popped %h)", s_st_valid, s_st_tag[15:8], tmp);
    else pass_cnt++;
    total++; if (s_ready !== 4'b0010) $display("FAIL max_regrant got %b want 0010", s_ready); else pass_cnt++;
    exp_q.push_back(dw(1, tagv[1]));
    infl_q.push_back({2'd1, tagv[1]});
    step();
    s_valid = '0;
    step();
    drain_status();
  endtask

  task automatic test_same_cycle();
    step();
    m_ready = 1'b1;
    set_desc(0, 8'h30);
    s_valid = 4'b0001;
    @(negedge clk);
    total++; if (s_ready !== 4'b0001) $display("FAIL same_first_grant got %b want 0001", s_ready); else pass_cnt++;
    exp_q.push_back(dw(0, 8'h30));
    step();
    set_desc(0, 8'h31);
    m_st_tag = {2'd0, 8'h30}; m_st_valid = 1'b1;
    exp_st_q.push_back({2'd0, 8'h30});
    @(negedge clk);
    total++; if (s_ready !== 4'b0001) $display("FAIL same_second_grant got %b want 0001", s_ready); else pass_cnt++;
    exp_q.push_back(dw(0, 8'h31));
    step();
    s_valid = '0;
    m_st_tag = {2'd3, 8'h77};
    step();
    m_st_valid = 1'b0;
    @(negedge clk);
    total++; if (s_st_valid !== 4'b0) $display("FAIL drop_zero_port got %b want 0", s_st_valid); else pass_cnt++;
    step();
    m_st_tag = {2'd0, 8'h31}; m_st_valid = 1'b1;
    exp_st_q.push_back({2'd0, 8'h31});
    step();
    m_st_valid = 1'b0;
    @(negedge clk);
    total++; if (s_st_valid !== 4'b0001) $display("FAIL same_count_kept got %b want 0001", s_st_valid); else pass_cnt++;
    step(); step();
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL same_busy_idle got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_enable();
    step();
    m_ready = 1'b0; enable = 1'b1;
    set_desc(3, 8'h40);
    s_valid = 4'b1000;
    @(negedge clk);
    total++; if (s_ready !== 4'b1000) $display("FAIL en_grant got %b want 1000", s_ready); else pass_cnt++;
    exp_q.push_back(dw(3, 8'h40));
    step();
    enable = 1'b0;
    set_desc(3, 8'h41);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (s_ready !== 4'b0) $display("FAIL en_blocked got %b want 0", s_ready); else pass_cnt++;
    end
    step();
    m_ready = 1'b1;
    @(negedge clk);
    total++; if (s_ready !== 4'b0) $display("FAIL en_blocked_drain got %b want 0", s_ready); else pass_cnt++;
    step();
    s_valid = '0;
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL en_busy_inflight got %b want 1", busy); else pass_cnt++;
    step();
    m_st_tag = {2'd3, 8'h40}; m_st_valid = 1'b1;
    exp_st_q.push_back({2'd3, 8'h40});
    step();
    m_st_valid = 1'b0;
    @(negedge clk);
    total++; if (s_st_valid !== 4'b1000) $display("FAIL en_status got %b want 1000", s_st_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL en_busy_fall got %b want 0", busy); else pass_cnt++;
    step();
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    step();
    m_ready = 1'b1;
    set_desc(0, 8'h50);
    set_desc(1, 8'h60);
    s_valid = 4'b0011;
    @(negedge clk);
    total++; if (s_ready !== 4'b0001) $display("FAIL rst_grant0 got %b want 0001", s_ready); else pass_cnt++;
    exp_q.push_back(dw(0, 8'h50));
    step();
    s_valid = 4'b0010;
    @(negedge clk);
    total++; if (s_ready !== 4'b0010) $display("FAIL rst_grant1 got %b want 0010", s_ready); else pass_cnt++;
    exp_q.push_back(dw(1, 8'h60));
    step();
    s_valid = '0; m_ready = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL rst_busy_before got %b want 1", busy); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || m_tag !== '0 || m_addr !== '0)
      $display("FAIL rst_async got %b/%b/%h/%h want 0/0/0/0", m_valid, busy, m_tag, m_addr);
    else pass_cnt++;
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    m_st_tag = {2'd0, 8'h50}; m_st_valid = 1'b1;
    step();
    m_st_tag = {2'd1, 8'h60};
    @(negedge clk);
    total++; if (s_st_valid !== 4'b0) $display("FAIL rst_drop0 got %b want 0", s_st_valid); else pass_cnt++;
    step();
    m_st_valid = 1'b0;
    @(negedge clk);
    total++; if (s_st_valid !== 4'b0) $display("FAIL rst_drop1 got %b want 0", s_st_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy_idle got %b want 0", busy); else pass_cnt++;
  endtask

  initial begin
    s_addr = '0; s_len = '0; s_tag = '0; s_id = '0; s_user = '0;
    test_reset();
    test_round_robin();
    test_hold();
    test_max_outstanding();
    test_same_cycle();
    test_enable();
    test_reset_mid();
    step(); step();
    total++; if (exp_q.size() != 0) $display("FAIL exp_q_empty got %0d want 0", exp_q.size()); else pass_cnt++;
    total++; if (exp_st_q.size() != 0) $display("FAIL status_q_empty got %0d want 0", exp_st_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
